muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with the ports listed below.
REQ-002 CLK  input  1  rising-edge clock.
REQ-003 RESET_N  input  1  asynchronous active-low reset.
REQ-004 DATA1  input  32  rs1 operand (multiplicand/dividend).
REQ-005 DATA2  input  32  rs2 operand (multiplier/divisor).
REQ-006 FUNC3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 START  input  1  request; sampled only in IDLE.
REQ-008 FLUSH  input  1  abort the in-flight operation (pipeline flush).
REQ-009 RESULT  output  32  registered result, held until the next DONE.
REQ-010 ZERO  output  1  registered; equals 1 when RESULT==0.
REQ-011 BUSY  output  1  high while an operation is in flight.
REQ-012 DONE  output  1  one-cycle pulse; RESULT is valid in the same cycle.

Function
REQ-013 States SHALL be IDLE, CALC and FINISH; a 5-bit counter SHALL track CALC iterations.
REQ-014 IDLE with START=1 and FLUSH=0 at an edge: latch DATA1, DATA2 and FUNC3, clear the counter, go to CALC, set BUSY=1.
REQ-015 CALC SHALL perform one radix-2 step per cycle for 32 cycles: shift-add for multiply, restoring for divide, on operand magnitudes.
REQ-016 After counter=31, CALC SHALL go to FINISH, which applies sign correction, registers RESULT/ZERO, pulses DONE=1, clears BUSY and returns to IDLE.
REQ-017 DONE SHALL assert exactly 33 edges after the START-sampling edge, for every FUNC3 including special cases.
REQ-018 MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32] with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
REQ-019 Division by zero: DIV/DIVU SHALL return 0xFFFFFFFF; REM/REMU SHALL return DATA1.
REQ-020 Signed overflow (0x80000000 / 0xFFFFFFFF): DIV SHALL return 0x80000000 and REM SHALL return 0.
REQ-021 Signed quotient SHALL truncate toward zero; the remainder SHALL take the sign of the dividend.
REQ-022 START while BUSY=1 SHALL be ignored, with no queuing.
REQ-023 FLUSH=1 in CALC or FINISH SHALL return the block to IDLE at the next edge: no DONE, RESULT/ZERO unchanged, BUSY=0.
REQ-024 If FLUSH and START are both high in IDLE, FLUSH SHALL win and nothing is started.
REQ-025 A START SHALL be accepted on the edge immediately following DONE (back-to-back operation).

Reset
REQ-026 RESET_N=0 SHALL immediately force IDLE, RESULT=0, ZERO=1, BUSY=0, DONE=0 and counter=0, including mid-operation.
REQ-027 After RESET_N deasserts, START SHALL be honoured on the first rising edge.

Configuration
REQ-028 Macro MULDIV_FAST_MUL_EN SHALL control multiply latency.
- Defined: FUNC3[2]=0 ops use a single-cycle 64-bit product and go IDLE->FINISH, so DONE asserts 1 edge after START.
- Not defined: all ops use the 33-edge iterative path.
- Divide latency is 33 edges either way.

Structure
REQ-029 The shared definitions file SHALL hold the FUNC3 encodings, state encodings and the iteration count (32).
REQ-030 One sub-module, div_step, SHALL implement a single combinational restoring-divide iteration (remainder/quotient in, shifted remainder/quotient out).

Verification
REQ-031 MUL 0x00000007 × 0xFFFFFFFD -> RESULT 0xFFFFFFEB; BUSY high for 33 cycles; DONE at edge +33.
REQ-032 DATA1=DATA2=0xFFFFFFFF -> expected RESULT per op:
- MULHU: 0xFFFFFFFE
- MULH: 0x00000000 with ZERO=1
- MULHSU: 0xFFFFFFFF
REQ-033 Divide special cases -> expected RESULT:
- DIV 0x80000000 / 0xFFFFFFFF: 0x80000000
- REM with the same operands: 0
- DIVU 100/0: 0xFFFFFFFF
- REMU 100/0: 0x00000064
REQ-034 Signed divide -20 / 6 -> DIV RESULT 0xFFFFFFFD; REM RESULT 0xFFFFFFFE.
REQ-035 Abort and busy handling:
- FLUSH at CALC cycle 10 of a DIV -> no DONE; BUSY=0 next cycle; RESULT unchanged.
- A START pulsed while BUSY -> ignored.
- A new START after the flush -> completes normally.
REQ-036 Reset and fast-multiply checks:
- RESET_N pulsed low mid-CALC -> outputs reach reset values without a clock edge.
- With MULDIV_FAST_MUL_EN, MUL 3×4 -> RESULT 0x0000000C with DONE 1 edge after START.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: op encodings, FSM states
// and iteration count. MULDIV_FAST_MUL_EN selects a single-cycle multiply path.
package muldiv_pkg;

    localparam int unsigned ITERATIONS = 32;
    localparam int unsigned CNT_W      = 5;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } func3_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_FINISH = 2'd2
    } state_e;

    // Magnitude of v when it is treated as a signed operand.
    function automatic logic [31:0] abs_if(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One combinational restoring-divide iteration: shift the next dividend bit into
// the partial remainder and subtract the divisor if it fits.
module div_step (
    input  logic [31:0] rem_in,
    input  logic [31:0] quo_in,
    input  logic [31:0] divisor,
    output logic [31:0] rem_out,
    output logic [31:0] quo_out
);

    logic [32:0] shifted;
    logic [32:0] diff;

    always_comb begin
        shifted = {rem_in, quo_in[31]};
        diff    = shifted - {1'b0, divisor};
        // A clear borrow bit means the divisor fits into the shifted remainder.
        if (!diff[32]) begin
            rem_out = diff[31:0];
            quo_out = {quo_in[30:0], 1'b1};
        end else begin
            rem_out = shifted[31:0];
            quo_out = {quo_in[30:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32 radix-2 steps on operand magnitudes,
// sign fix-up in FINISH. Define MULDIV_FAST_MUL_EN for a single-cycle multiply.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [31:0] DATA1,
    input  logic [31:0] DATA2,
    input  logic [2:0]  FUNC3,
    input  logic        START,
    input  logic        FLUSH,
    output logic [31:0] RESULT,
    output logic        ZERO,
    output logic        BUSY,
    output logic        DONE
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    func3_e             op_q, op_d;
    // acc_hi/acc_lo hold {product} for multiply and {remainder, quotient} for divide.
    logic [31:0]        acc_hi_q, acc_hi_d;
    logic [31:0]        acc_lo_q, acc_lo_d;
    logic [31:0]        opnd_q, opnd_d;
    logic [31:0]        a_raw_q, a_raw_d;
    logic               neg_a_q, neg_a_d;
    logic               neg_b_q, neg_b_d;
    logic               div_zero_q, div_zero_d;
    logic [31:0]        result_q, result_d;
    logic               zero_q, zero_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               sa, sb;
    logic [32:0]        mul_sum;
    logic [63:0]        mul_next;
    logic [31:0]        div_rem_next, div_quo_next;
    logic [63:0]        prod_mag, prod_s;
    logic [31:0]        quo_s, rem_s;
    logic [31:0]        final_res;

    div_step u_div_step (
        .rem_in  (acc_hi_q),
        .quo_in  (acc_lo_q),
        .divisor (opnd_q),
        .rem_out (div_rem_next),
        .quo_out (div_quo_next)
    );

    // Shift-add: add the multiplicand when the current multiplier bit is set, then shift right.
    always_comb begin
        mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : 33'd0);
        mul_next = {mul_sum, acc_lo_q[31:1]};
    end

    // Operand signedness for the incoming request.
    always_comb begin
        if (FUNC3[2]) begin
            sa = ~FUNC3[0];
            sb = ~FUNC3[0];
        end else begin
            sa = (FUNC3[1:0] != 2'b11);
            sb = (FUNC3[1:0] == 2'b00) || (FUNC3[1:0] == 2'b01);
        end
    end

    always_comb begin
`ifdef MULDIV_FAST_MUL_EN
        prod_mag = {32'd0, opnd_q} * {32'd0, acc_lo_q};
`else
        prod_mag = {acc_hi_q, acc_lo_q};
`endif
        prod_s = (neg_a_q ^ neg_b_q) ? (~prod_mag + 64'd1) : prod_mag;
        quo_s  = (neg_a_q ^ neg_b_q) ? (~acc_lo_q + 32'd1) : acc_lo_q;
        rem_s  = neg_a_q ? (~acc_hi_q + 32'd1) : acc_hi_q;
        case (op_q)
            F3_MUL:                       final_res = prod_s[31:0];
            F3_MULH, F3_MULHSU, F3_MULHU: final_res = prod_s[63:32];
            F3_DIV, F3_DIVU:              final_res = div_zero_q ? 32'hFFFF_FFFF : quo_s;
            default:                      final_res = div_zero_q ? a_raw_q : rem_s;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        acc_hi_d   = acc_hi_q;
        acc_lo_d   = acc_lo_q;
        opnd_d     = opnd_q;
        a_raw_d    = a_raw_q;
        neg_a_d    = neg_a_q;
        neg_b_d    = neg_b_q;
        div_zero_d = div_zero_q;
        result_d   = result_q;
        zero_d     = zero_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (START && !FLUSH) begin
                    op_d       = func3_e'(FUNC3);
                    a_raw_d    = DATA1;
                    neg_a_d    = sa & DATA1[31];
                    neg_b_d    = sb & DATA2[31];
                    div_zero_d = (DATA2 == 32'd0);
                    acc_hi_d   = 32'd0;
                    if (FUNC3[2]) begin
                        acc_lo_d = abs_if(DATA1, sa);
                        opnd_d   = abs_if(DATA2, sb);
                    end else begin
                        acc_lo_d = abs_if(DATA2, sb);
                        opnd_d   = abs_if(DATA1, sa);
                    end
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_CALC;
`ifdef MULDIV_FAST_MUL_EN
                    if (!FUNC3[2]) state_d = S_FINISH;
`endif
                end
            end
            S_CALC: begin
                if (FLUSH) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    if (op_q[2]) begin
                        acc_hi_d = div_rem_next;
                        acc_lo_d = div_quo_next;
                    end else begin
                        acc_hi_d = mul_next[63:32];
                        acc_lo_d = mul_next[31:0];
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(ITERATIONS - 1)) state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
                if (!FLUSH) begin
                    result_d = final_res;
                    zero_d   = (final_res == 32'd0);
                    done_d   = 1'b1;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_q       <= F3_MUL;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            opnd_q     <= '0;
            a_raw_q    <= '0;
            neg_a_q    <= 1'b0;
            neg_b_q    <= 1'b0;
            div_zero_q <= 1'b0;
            result_q   <= '0;
            zero_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            acc_hi_q   <= acc_hi_d;
            acc_lo_q   <= acc_lo_d;
            opnd_q     <= opnd_d;
            a_raw_q    <= a_raw_d;
            neg_a_q    <= neg_a_d;
            neg_b_q    <= neg_b_d;
            div_zero_q <= div_zero_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign RESULT = result_q;
    assign ZERO   = zero_q;
    assign BUSY   = busy_q;
    assign DONE   = done_q;

endmodule
